mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port main memory between instruction fetch (I-side) and
//  the data cache/MEM stage (D-side). Sequences one transaction at a time with
//  a fixed-latency memory and returns data, a done pulse and stall signals.
//  The pipeline ORs i_stall/d_stall into cache_stall so hazard logic freezes.
// PARAMETERS
//  MEM_LAT  4  cycles from mem_en cycle to the cycle mem_rdata is valid (>=1)
//  CNT_W    3  latency counter width; MEM_LAT <= 2**CNT_W-1
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   synchronous, active-low reset
//  i_req      in   1   I-side read request, held until i_done
//  i_addr     in   16  I-side word address, stable while i_req high
//  i_rdata    out  16  I-side read data, valid in i_done cycle
//  i_done     out  1   one-cycle completion pulse, I-side
//  i_stall    out  1   i_req & ~i_done (combinational)
//  d_req      in   1   D-side request, held until d_done
//  d_wr       in   1   1=write, 0=read; stable while d_req high
//  d_addr     in   16  D-side word address
//  d_wdata    in   16  D-side write data
//  d_rdata    out  16  D-side read data, valid in d_done cycle
//  d_done     out  1   one-cycle completion pulse, D-side
//  d_stall    out  1   d_req & ~d_done (combinational)
//  mem_en     out  1   one-cycle memory command strobe (registered)
//  mem_wr     out  1   write select, valid with mem_en
//  mem_addr   out  16  memory address, valid with mem_en
//  mem_wdata  out  16  memory write data, valid with mem_en
//  mem_rdata  in   16  memory read data, valid MEM_LAT cycles after mem_en
// BEHAVIOUR
//  - States: IDLE, ISSUE, WAIT, DONE. Reset (rst==0 at edge): state=IDLE, all
//    registered outputs, i_rdata, d_rdata, owner, counter = 0.
//  - IDLE: reqs sampled. None -> stay. Else pick winner, latch owner/addr/wr/
//    wdata (I-side: wr=0, wdata=0) -> ISSUE. Tie: D wins (fixed priority).
//  - ISSUE: mem_en=1 with latched mem_* for exactly this cycle -> WAIT, cnt=MEM_LAT-1.
//  - WAIT: cnt decrements; in cnt==0 cycle mem_rdata is captured into owner's
//    rdata reg (reads only; writes leave rdata unchanged) -> DONE.
//  - DONE: owner's done=1 one cycle; other side's done=0; reqs ignored -> IDLE.
//  - Latency: req in IDLE cycle T -> mem_en T+1 -> rdata T+1+MEM_LAT -> done
//    T+2+MEM_LAT. Min gap between mem_en strobes: MEM_LAT+3 cycles.
//  - Req still high in cycle after done = new transaction (sampled in IDLE).
//  - Req dropped mid-transaction: transaction completes, done still pulses.
//  - Loser's req stays pending; considered at next IDLE, never lost.
//  - Reset mid-transaction: return to IDLE next cycle, in-flight mem_rdata
//    discarded, no done pulse issued.
//  - mem_wr/mem_addr/mem_wdata hold last value outside ISSUE; only mem_en qualifies.
// CONFIGURATION
//  MEMARB_RR_EN defined: tie in IDLE goes to side NOT granted last; last-grant
//   reg resets to I (so first tie after reset goes to D); prevents starvation.
//  MEMARB_RR_EN undefined: fixed D>I priority; I may starve under continuous D.
// TESTING (MEM_LAT=4, cycle 0 = first cycle req high in IDLE)
//  1 I read addr 0x0040, mem_rdata=0xBEEF in cyc5 -> mem_en cyc1 wr=0 addr
//    0x0040; i_done cyc6, i_rdata=0xBEEF; i_stall=1 cyc0-5, 0 cyc6.
//  2 D write addr 0x0100 data 0x1234 -> mem_en cyc1 mem_wr=1 addr/data match;
//    d_done cyc6; d_rdata unchanged.
//  3 i_req & d_req both cyc0 -> D served (done cyc6); I mem_en cyc8, i_done
//    cyc13; i_stall high cyc0-12.
//  4 D read in flight, rst=0 in cyc3 -> cyc4 state IDLE, all outputs 0; no
//    d_done in cyc6 despite mem_rdata in cyc5.
//  5 d_req held high across 2 transactions -> mem_en cyc1 and cyc8, d_done
//    cyc6 and cyc13.
//  6 d_req and i_req held continuously -> no RR: D only; MEMARB_RR_EN:
//    grants alternate D,I,D,I at mem_en cyc1,8,15,22.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, fixed-latency main memory between the
// instruction-fetch side (I) and the data side (D).
//
// Only one transaction is in flight at a time. The state sequence is
// IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//
// Ports
//   clk, rst                    clock; synchronous active-low reset
//   i_req, i_addr               I-side read request and word address
//   i_rdata, i_done, i_stall    I-side read data, completion pulse, stall
//   d_req, d_wr, d_addr,        D-side request, write select, word address
//   d_wdata                     and write data
//   d_rdata, d_done, d_stall    D-side read data, completion pulse, stall
//   mem_en, mem_wr, mem_addr,   memory command (one-cycle strobe plus
//   mem_wdata                   qualifiers, all registered)
//   mem_rdata                   memory read data, valid MEM_LAT cycles
//                               after the mem_en cycle
//
// Configuration macro MEMARB_RR_EN
//   defined:   a tie goes to the side not granted last. The last-grant
//              register resets to I, so the first tie goes to D.
//   undefined: fixed priority, D before I.
module mem_arbiter #(
  parameter int MEM_LAT = 4,
  parameter int CNT_W   = 3,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             owner_d;   // 1: current transaction belongs to D-side
  logic             win_d;     // arbitration result for this IDLE cycle

`ifdef MEMARB_RR_EN
  logic             last_d;    // 1: most recent grant went to D-side
`endif

  // Stall while a request is outstanding. The stall drops in the done cycle
  // so the pipeline can advance on the same edge that the data is consumed.
  assign i_stall = i_req & ~i_done;
  assign d_stall = d_req & ~d_done;

  // Arbitration.
  // win_d only matters when at least one request is present:
  //   - D alone, or a fixed-priority tie, selects D.
  //   - I alone selects I.
  //   - With round robin, a tie goes to the side not granted last.
  always_comb begin
    win_d = d_req;
`ifdef MEMARB_RR_EN
    if (i_req && d_req) win_d = ~last_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      owner_d   <= 1'b0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
`ifdef MEMARB_RR_EN
      last_d    <= 1'b0;
`endif
    end else begin
      // Strobes default low so each one lasts exactly one cycle.
      mem_en <= 1'b0;
      i_done <= 1'b0;
      d_done <= 1'b0;

      case (state)
        // Grant stage: latch the winner's command. mem_en is registered,
        // so the command appears in the following (ISSUE) cycle.
        IDLE: begin
          if (i_req || d_req) begin
            owner_d   <= win_d;
            mem_en    <= 1'b1;
            mem_wr    <= win_d ? d_wr : 1'b0;
            mem_addr  <= win_d ? d_addr : i_addr;
            mem_wdata <= win_d ? d_wdata : '0;
`ifdef MEMARB_RR_EN
            last_d    <= win_d;
`endif
            state     <= ISSUE;
          end
        end

        // Issue stage: the strobe is visible this cycle. Start the latency
        // count so that the cnt==0 WAIT cycle is MEM_LAT cycles after mem_en.
        ISSUE: begin
          cnt   <= CNT_W'(MEM_LAT - 1);
          state <= WAIT;
        end

        // Wait stage: capture read data in the cycle it is valid. A write
        // leaves the owner's rdata register untouched. mem_wr still holds the
        // latched command here.
        WAIT: begin
          if (cnt == '0) begin
            if (owner_d) begin
              if (!mem_wr) d_rdata <= mem_rdata;
              d_done <= 1'b1;
            end else begin
              i_rdata <= mem_rdata;
              i_done  <= 1'b1;
            end
            state <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        // Done stage: the done pulse is visible this cycle. Requests are not
        // sampled here; a request still held is picked up in the next IDLE.
        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed test of mem_arbiter with MEM_LAT=4.
// Cycle 0 of each scenario is the first cycle in which a request is high in
// IDLE. Inputs are applied just after a rising edge; outputs are checked 1ns
// later, within the same cycle.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic        i_done, i_stall, d_done, d_stall, mem_en, mem_wr;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.MEM_LAT(4), .CNT_W(3), .DATA_W(16), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .i_stall(i_stall),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges and check that every registered output is
  // cleared. Returns at the start of the first IDLE cycle after release.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    i_req = 0; d_req = 0; d_wr = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 16'hDEAD;
    tick(); tick();
    chk_eq({tag, "_en"},    16'(mem_en), 16'd0);
    chk_eq({tag, "_wr"},    16'(mem_wr), 16'd0);
    chk_eq({tag, "_addr"},  mem_addr,    16'h0);
    chk_eq({tag, "_wdata"}, mem_wdata,   16'h0);
    chk_eq({tag, "_irdata"}, i_rdata,    16'h0);
    chk_eq({tag, "_drdata"}, d_rdata,    16'h0);
    chk_eq({tag, "_idone"}, 16'(i_done), 16'd0);
    chk_eq({tag, "_ddone"}, 16'(d_done), 16'd0);
    rst = 1'b1;
    tick();
  endtask

  initial begin
    do_reset("rst0");

    // 1: I read at 0x0040; memory returns 0xBEEF in cycle 5.
    i_req = 1; i_addr = 16'h0040;
    for (int c = 0; c <= 6; c++) begin
      mem_rdata = (c == 5) ? 16'hBEEF : 16'hDEAD;
      #1;
      chk_eq($sformatf("t1_en_c%0d", c), 16'(mem_en), 16'(c == 1));
      chk_eq($sformatf("t1_idone_c%0d", c), 16'(i_done), 16'(c == 6));
      chk_eq($sformatf("t1_istall_c%0d", c), 16'(i_stall), 16'(c < 6));
      if (c == 1) begin
        chk_eq("t1_wr", 16'(mem_wr), 16'd0);
        chk_eq("t1_addr", mem_addr, 16'h0040);
      end
      if (c == 6) begin
        chk_eq("t1_irdata", i_rdata, 16'hBEEF);
        i_req = 0;
      end
      tick();
    end

    // 5: D read held across two transactions.
    d_req = 1; d_wr = 0; d_addr = 16'h0200; d_wdata = 16'h0;
    for (int c = 0; c <= 13; c++) begin
      mem_rdata = (c == 5) ? 16'h1111 : (c == 12) ? 16'h2222 : 16'hDEAD;
      #1;
      chk_eq($sformatf("t5_en_c%0d", c), 16'(mem_en), 16'(c == 1 || c == 8));
      chk_eq($sformatf("t5_ddone_c%0d", c), 16'(d_done), 16'(c == 6 || c == 13));
      chk_eq($sformatf("t5_dstall_c%0d", c), 16'(d_stall), 16'(!(c == 6 || c == 13)));
      if (c == 8) chk_eq("t5_addr_c8", mem_addr, 16'h0200);
      if (c == 6) chk_eq("t5_drdata_c6", d_rdata, 16'h1111);
      if (c == 13) begin
        chk_eq("t5_drdata_c13", d_rdata, 16'h2222);
        d_req = 0;
      end
      tick();
    end

    // 2: D write at 0x0100 with data 0x1234; d_rdata must keep 0x2222.
    d_req = 1; d_wr = 1; d_addr = 16'h0100; d_wdata = 16'h1234;
    for (int c = 0; c <= 6; c++) begin
      mem_rdata = (c == 5) ? 16'hFFFF : 16'hDEAD;
      #1;
      chk_eq($sformatf("t2_en_c%0d", c), 16'(mem_en), 16'(c == 1));
      chk_eq($sformatf("t2_ddone_c%0d", c), 16'(d_done), 16'(c == 6));
      if (c == 1) begin
        chk_eq("t2_wr", 16'(mem_wr), 16'd1);
        chk_eq("t2_addr", mem_addr, 16'h0100);
        chk_eq("t2_wdata", mem_wdata, 16'h1234);
      end
      if (c == 3) chk_eq("t2_addr_hold", mem_addr, 16'h0100);
      if (c == 6) begin
        chk_eq("t2_drdata", d_rdata, 16'h2222);
        d_req = 0; d_wr = 0;
      end
      tick();
    end

    // 3: simultaneous requests, D wins; I follows and is served second.
    do_reset("rst3");
    d_req = 1; d_wr = 0; d_addr = 16'h0300; d_wdata = 16'h5555;
    i_req = 1; i_addr = 16'h0400;
    for (int c = 0; c <= 13; c++) begin
      mem_rdata = (c == 5) ? 16'hAAAA : (c == 12) ? 16'hBBBB : 16'hDEAD;
      #1;
      chk_eq($sformatf("t3_en_c%0d", c), 16'(mem_en), 16'(c == 1 || c == 8));
      chk_eq($sformatf("t3_ddone_c%0d", c), 16'(d_done), 16'(c == 6));
      chk_eq($sformatf("t3_idone_c%0d", c), 16'(i_done), 16'(c == 13));
      chk_eq($sformatf("t3_istall_c%0d", c), 16'(i_stall), 16'(c < 13));
      if (c == 1) begin
        chk_eq("t3_addr_c1", mem_addr, 16'h0300);
        chk_eq("t3_wdata_c1", mem_wdata, 16'h5555);
      end
      if (c == 6) begin
        chk_eq("t3_drdata", d_rdata, 16'hAAAA);
        d_req = 0;
      end
      if (c == 8) begin
        chk_eq("t3_addr_c8", mem_addr, 16'h0400);
        chk_eq("t3_wr_c8", 16'(mem_wr), 16'd0);
        chk_eq("t3_wdata_c8", mem_wdata, 16'h0);
      end
      if (c == 13) begin
        chk_eq("t3_irdata", i_rdata, 16'hBBBB);
        i_req = 0;
      end
      tick();
    end

    // 6: both sides request continuously.
    do_reset("rst6");
    d_req = 1; d_wr = 0; d_addr = 16'h0500;
    i_req = 1; i_addr = 16'h0600;
    mem_rdata = 16'hDEAD;
    for (int c = 0; c <= 22; c++) begin
      #1;
      chk_eq($sformatf("t6_en_c%0d", c), 16'(mem_en),
             16'(c == 1 || c == 8 || c == 15 || c == 22));
`ifdef MEMARB_RR_EN
      if (c == 1 || c == 15) chk_eq($sformatf("t6_addr_c%0d", c), mem_addr, 16'h0500);
      if (c == 8 || c == 22) chk_eq($sformatf("t6_addr_c%0d", c), mem_addr, 16'h0600);
`else
      if (c == 1 || c == 8 || c == 15 || c == 22)
        chk_eq($sformatf("t6_addr_c%0d", c), mem_addr, 16'h0500);
      chk_eq($sformatf("t6_istall_c%0d", c), 16'(i_stall), 16'd1);
`endif
      tick();
    end

    // 4: reset asserted in cycle 3 of a D read; no done pulse may follow.
    do_reset("rst4");
    d_req = 1; d_wr = 0; d_addr = 16'h0700; d_wdata = 16'h7777;
    for (int c = 0; c <= 7; c++) begin
      mem_rdata = (c == 5) ? 16'hCCCC : 16'hDEAD;
      if (c == 3) begin rst = 0; d_req = 0; end
      if (c == 4) rst = 1;
      #1;
      chk_eq($sformatf("t4_en_c%0d", c), 16'(mem_en), 16'(c == 1));
      chk_eq($sformatf("t4_ddone_c%0d", c), 16'(d_done), 16'd0);
      if (c == 1) chk_eq("t4_addr_c1", mem_addr, 16'h0700);
      if (c == 4) begin
        chk_eq("t4_addr_c4", mem_addr, 16'h0);
        chk_eq("t4_wdata_c4", mem_wdata, 16'h0);
        chk_eq("t4_wr_c4", 16'(mem_wr), 16'd0);
      end
      if (c == 6) chk_eq("t4_drdata_c6", d_rdata, 16'h0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
